// File: rtl/validador_posicao.sv
// Ship placement validator: checks a requested ship against the player's occupancy
// board (bounds, then overlap cell by cell) and commits it one cell per cycle when clean.
module validador_posicao #(
    parameter int COORD_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valida,
    input  logic [2:0]         tipo,
    input  logic [COORD_W-1:0] X1,
    input  logic [COORD_W-1:0] Y1,
    input  logic               direcao,
    input  logic [2:0]         orientacao,
    input  logic               jogador,
    input  logic               limpa,
    output logic               conflito,
    output logic               pronto,
    output logic               ocupado,
    input  logic               le_jogador,
    input  logic [COORD_W-1:0] le_x,
    input  logic [COORD_W-1:0] le_y,
    output logic               le_ocupado
);
    localparam int CELLS  = 1 << (2 * COORD_W);
    localparam int ADDR_W = 2 * COORD_W;
    localparam int EXT_W  = COORD_W + 1;
    localparam int MAX_N  = 5;
    localparam logic [2:0] TIPO_HIDRO = 3'd2;
    localparam logic [2:0] TIPO_MAX   = 3'd4;

    typedef enum logic [2:0] {
        OCIOSO,
        CALCULA,
        VERIFICA,
        GRAVA,
        FIM
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         idx_reg, idx_next;
    logic               conflito_reg, conflito_next;
    logic               valida_prev_reg;
    logic               latch_req;

    logic [2:0]         tipo_reg;
    logic [COORD_W-1:0] x_reg, y_reg;
    logic               dir_reg;
    logic               ori_reg;
    logic               jog_reg;

    logic [CELLS-1:0]   board_reg [2];

    logic               valida_rise;
    logic [2:0]         n_cells;
    logic [EXT_W-1:0]   along_base, perp_base;
    logic [EXT_W-1:0]   cell_x [MAX_N];
    logic [EXT_W-1:0]   cell_y [MAX_N];
    logic [MAX_N-1:0]   cell_used;
    logic [MAX_N-1:0]   cell_oob;
    logic               any_oob;
    logic [ADDR_W-1:0]  cur_addr;
    logic               cur_busy;
    logic               last_cell;
    logic               grava_en;
    logic               unused_bits;

    // Only bit 0 of orientacao selects the wing side.
    assign unused_bits = ^orientacao[2:1];

    assign valida_rise = valida & ~valida_prev_reg;

    always_comb begin
        n_cells = 3'd0;
        if (tipo_reg <= TIPO_MAX) begin
            n_cells = tipo_reg + 3'd1;
        end
    end

    // Along/perpendicular bases are swapped for vertical ships; one extra bit catches overflow.
    assign along_base = dir_reg ? {1'b0, y_reg} : {1'b0, x_reg};
    assign perp_base  = dir_reg ? {1'b0, x_reg} : {1'b0, y_reg};

    for (genvar gi = 0; gi < MAX_N; gi++) begin : g_cell
        logic [EXT_W-1:0] along_off;
        logic             perp_pos;
        logic             perp_neg;
        logic [EXT_W-1:0] along_c;
        logic [EXT_W-1:0] perp_c;

        always_comb begin
            along_off = EXT_W'(gi);
            perp_pos  = 1'b0;
            perp_neg  = 1'b0;
            if (tipo_reg == TIPO_HIDRO) begin
                if (gi == 1) begin
                    along_off = EXT_W'(2);
                end else if (gi == 2) begin
                    along_off = EXT_W'(1);
                    perp_pos  = ~ori_reg;
                    perp_neg  = ori_reg;
                end
            end
        end

        // Stepping below zero wraps to all ones, which sets the overflow bit.
        assign along_c = along_base + along_off;
        assign perp_c  = perp_pos ? perp_base + EXT_W'(1) :
                         perp_neg ? perp_base - EXT_W'(1) : perp_base;

        assign cell_x[gi]    = dir_reg ? perp_c : along_c;
        assign cell_y[gi]    = dir_reg ? along_c : perp_c;
        assign cell_used[gi] = (3'(gi) < n_cells);
        assign cell_oob[gi]  = cell_used[gi] & (cell_x[gi][COORD_W] | cell_y[gi][COORD_W]);
    end

    assign any_oob   = (|cell_oob) | (tipo_reg > TIPO_MAX);
    assign cur_addr  = {cell_y[idx_reg][COORD_W-1:0], cell_x[idx_reg][COORD_W-1:0]};
    assign cur_busy  = board_reg[jog_reg][cur_addr];
    assign last_cell = (idx_reg == n_cells - 3'd1);
    assign grava_en  = (state_reg == GRAVA) && !limpa;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        conflito_next = conflito_reg;
        latch_req     = 1'b0;
        if (limpa) begin
            state_next = OCIOSO;
            idx_next   = 3'd0;
        end else begin
            case (state_reg)
                OCIOSO: begin
                    if (valida_rise) begin
                        latch_req  = 1'b1;
                        state_next = CALCULA;
                    end
                end
                CALCULA: begin
                    idx_next = 3'd0;
                    if (any_oob) begin
                        state_next    = FIM;
                        conflito_next = 1'b1;
                    end else begin
                        state_next = VERIFICA;
                    end
                end
                VERIFICA: begin
                    if (cur_busy) begin
                        state_next    = FIM;
                        conflito_next = 1'b1;
                        idx_next      = 3'd0;
                    end else if (last_cell) begin
                        state_next = GRAVA;
                        idx_next   = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
                GRAVA: begin
                    if (last_cell) begin
                        state_next    = FIM;
                        conflito_next = 1'b0;
                        idx_next      = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
                FIM: begin
                    state_next = OCIOSO;
                end
                default: begin
                    state_next = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= OCIOSO;
            idx_reg         <= 3'd0;
            conflito_reg    <= 1'b0;
            valida_prev_reg <= 1'b0;
            tipo_reg        <= 3'd0;
            x_reg           <= '0;
            y_reg           <= '0;
            dir_reg         <= 1'b0;
            ori_reg         <= 1'b0;
            jog_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            conflito_reg    <= conflito_next;
            valida_prev_reg <= valida;
            if (latch_req) begin
                tipo_reg <= tipo;
                x_reg    <= X1;
                y_reg    <= Y1;
                dir_reg  <= direcao;
                ori_reg  <= orientacao[0];
                jog_reg  <= jogador;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || limpa) begin
            board_reg[0] <= '0;
            board_reg[1] <= '0;
        end else if (grava_en) begin
            board_reg[jog_reg][cur_addr] <= 1'b1;
        end
    end

    assign conflito   = conflito_reg;
    assign pronto     = (state_reg == FIM);
    assign ocupado    = (state_reg != OCIOSO);
    assign le_ocupado = board_reg[le_jogador][{le_y, le_x}];

endmodule

// File: tb/tb_validador_posicao.sv
// Bench for validador_posicao: directed scenarios plus random placements checked
// against a cell-list model of both boards.
`timescale 1ns/1ps
module tb_validador_posicao;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset, valida, direcao, jogador, limpa, le_jogador;
    logic [2:0]   tipo, orientacao;
    logic [W-1:0] X1, Y1, le_x, le_y;
    logic         conflito, pronto, ocupado, le_ocupado;

    always #5 clk = ~clk;

    validador_posicao #(.COORD_W(W)) dut (
        .clk(clk), .reset(reset), .valida(valida), .tipo(tipo), .X1(X1), .Y1(Y1),
        .direcao(direcao), .orientacao(orientacao), .jogador(jogador), .limpa(limpa),
        .conflito(conflito), .pronto(pronto), .ocupado(ocupado),
        .le_jogador(le_jogador), .le_x(le_x), .le_y(le_y), .le_ocupado(le_ocupado)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;
    bit model_board [2][8][8];
    int m_cx [5];
    int m_cy [5];
    int m_n;
    bit m_oob;
    bit last_conf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ship shape as a list of (along, perpendicular) offsets, then mapped onto the grid.
    task automatic model_cells(input int t, input int x, input int y, input int d, input int o);
        int a [5];
        int p [5];
        m_oob = 0;
        m_n   = 0;
        if (t > 4) begin
            m_oob = 1;
        end else begin
            for (int i = 0; i < 5; i++) begin
                a[i] = i;
                p[i] = 0;
            end
            if (t == 2) begin
                m_n  = 3;
                a[1] = 2;
                a[2] = 1;
                p[2] = (o % 2 == 1) ? -1 : 1;
            end else begin
                m_n = t + 1;
            end
            for (int i = 0; i < m_n; i++) begin
                m_cx[i] = (d != 0) ? x + p[i] : x + a[i];
                m_cy[i] = (d != 0) ? y + a[i] : y + p[i];
                if (m_cx[i] < 0 || m_cx[i] > 7 || m_cy[i] < 0 || m_cy[i] > 7) m_oob = 1;
            end
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < 2; p++)
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    model_board[p][x][y] = 0;
    endtask

    task automatic sweep(input string tag);
        for (int p = 0; p < 2; p++)
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    @(negedge clk);
                    le_jogador = 1'(p);
                    le_x       = 3'(x);
                    le_y       = 3'(y);
                    #1;
                    check(tag, le_ocupado, model_board[p][x][y]);
                end
    endtask

    task automatic do_req(input int jog, input int t, input int x, input int y,
                          input int d, input int o, input bit stress);
        int  k;
        int  lat;
        int  exp_lat;
        bit  exp_conf;
        model_cells(t, x, y, d, o);
        if (m_oob) begin
            exp_conf = 1;
            exp_lat  = 1;
        end else begin
            k = -1;
            for (int i = 0; i < m_n; i++)
                if (k < 0 && model_board[jog][m_cx[i]][m_cy[i]]) k = i;
            if (k >= 0) begin
                exp_conf = 1;
                exp_lat  = k + 2;
            end else begin
                exp_conf = 0;
                exp_lat  = 2 * m_n + 1;
            end
        end

        @(negedge clk);
        jogador    = 1'(jog);
        tipo       = 3'(t);
        X1         = 3'(x);
        Y1         = 3'(y);
        direcao    = 1'(d);
        orientacao = 3'(o);
        valida     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_e0", ocupado, 1);
        check("no_pronto_e0", pronto, 0);
        // Inputs change after sampling; the check must use the latched request.
        tipo       = 3'($urandom_range(0, 7));
        X1         = 3'(x) ^ 3'b101;
        Y1         = 3'($urandom_range(0, 7));
        direcao    = 1'($urandom_range(0, 1));
        orientacao = 3'($urandom_range(0, 7));
        jogador    = 1'($urandom_range(0, 1));
        if (stress) valida = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (stress && lat == 1) valida = 1'b1;
        end while (!pronto && lat < 40);
        check("latency", lat, exp_lat);
        check("conflito", conflito, exp_conf);
        last_conf = exp_conf;
        @(negedge clk);
        check("pronto_single_pulse", pronto, 0);
        check("idle_after_fim", ocupado, 0);
        if (stress) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("no_retrigger", pronto, 0);
                check("no_retrigger_busy", ocupado, 0);
            end
        end
        valida = 1'b0;
        @(posedge clk);
        if (!exp_conf)
            for (int i = 0; i < m_n; i++) model_board[jog][m_cx[i]][m_cy[i]] = 1;
        $display("req jog=%0d tipo=%0d x=%0d y=%0d dir=%0d ori=%0d stress=%0d -> conflito=%0d latency=%0d (expected %0d/%0d)",
                 jog, t, x, y, d, o, stress, conflito, lat, exp_conf, exp_lat);
        sweep("board");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valida = 1'b0; limpa = 1'b0; tipo = 3'd0; X1 = '0; Y1 = '0;
        direcao = 1'b0; orientacao = 3'd0; jogador = 1'b0;
        le_jogador = 1'b0; le_x = '0; le_y = '0;
        last_conf = 0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_conflito", conflito, 0);
        check("reset_pronto", pronto, 0);
        check("reset_ocupado", ocupado, 0);
        sweep("reset_board");

        do_req(0, 4, 0, 0, 0, 0, 0);   // porta-avioes accepted, 11 cycles
        do_req(0, 3, 5, 0, 0, 0, 0);   // runs past column 7
        do_req(0, 2, 3, 0, 0, 1, 0);   // wing below row 0
        do_req(0, 1, 3, 0, 1, 0, 0);   // overlap at first cell
        do_req(1, 1, 3, 0, 1, 0, 0);   // same ship on empty board 1
        do_req(1, 2, 2, 2, 1, 0, 0);   // vertical hidroaviao
        do_req(1, 0, 6, 6, 0, 0, 1);   // held valida, re-edge while busy

        // Clear during commit: partially written ship must vanish.
        @(negedge clk);
        jogador = 1'b0; tipo = 3'd4; X1 = 3'd0; Y1 = 3'd7; direcao = 1'b0;
        orientacao = 3'd0; valida = 1'b1;
        le_jogador = 1'b0; le_x = 3'd0; le_y = 3'd7;
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("limpa_busy_grava", ocupado, 1);
        check("limpa_partial_write", le_ocupado, 1);
        limpa = 1'b1;
        @(posedge clk);
        @(negedge clk);
        limpa = 1'b0;
        check("limpa_ocupado", ocupado, 0);
        check("limpa_pronto", pronto, 0);
        check("limpa_conflito_kept", conflito, last_conf);
        clear_model();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("limpa_no_pronto", pronto, 0);
        end
        valida = 1'b0;
        @(posedge clk);
        sweep("limpa_board");

        for (int r = 0; r < 40; r++) begin
            do_req($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   1'($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of the overlap scan.
        do_req(0, 4, 6, 0, 0, 0, 0);
        @(negedge clk);
        jogador = 1'b0; tipo = 3'd4; X1 = 3'd0; Y1 = 3'd5; direcao = 1'b0; valida = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_busy", ocupado, 1);
        reset  = 1'b1;
        valida = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_conflito", conflito, 0);
        check("reset_mid_pronto", pronto, 0);
        check("reset_mid_ocupado", ocupado, 0);
        clear_model();
        sweep("reset_mid_board");
        do_req(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
